// File: rtl/gj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gj_pkg
// Description : Shared constants, fixed-point types, FSM state encoding and
//               the W+1 -> W bit saturation helper for the Gauss-Jordan
//               row-elimination stage.
// Revision    : 1.0  initial release
// ============================================================================
package gj_pkg;

    localparam int N    = 6;    // matrix dimension
    localparam int W    = 27;   // signed element width
    localparam int FRAC = 16;   // fractional bits (Q11.16)

    typedef logic signed [W-1:0] fix_t;
    typedef fix_t [N-1:0]        row_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_CALC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } gj_state_e;

    // Clamp a W+1-bit signed value into the signed W-bit range.
    // The value fits when its top two bits agree.
    function automatic fix_t sat_w(input logic signed [W:0] x);
        fix_t y;
        if (x[W] != x[W-1]) begin
            y = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = x[W-1:0];
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fix_msub.sv
`default_nettype none
// ============================================================================
// Module      : fix_msub
// Description : One combinational elimination lane:
//               y = sat(a - ((f * p) >>> FRAC))
//               The product is kept at full 2W-bit precision, the shift
//               truncates toward minus infinity, and the result saturates
//               to the signed W-bit range.
// Ports       : a  in  W  element of the row being updated
//               f  in  W  row factor (element in the pivot column)
//               p  in  W  matching element of the normalized pivot row
//               y  out W  saturated updated element
// Revision    : 1.0  initial release
// ============================================================================
module fix_msub
    import gj_pkg::*;
#(
    parameter int FRAC_BITS = gj_pkg::FRAC
) (
    input  fix_t a,
    input  fix_t f,
    input  fix_t p,
    output fix_t y
);

    localparam int PW = 2 * W;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [PW:0]   diff;
    logic signed [W:0]    clip;

    always_comb begin
        prod    = f * p;
        shifted = prod >>> FRAC_BITS;
        // The subtraction is carried at full width: a shifted product can
        // reach ~2W-FRAC bits, and narrowing it before the subtract would
        // wrap instead of clamp.
        diff    = a - shifted;
        if (diff[PW:W] == {(PW-W+1){diff[PW]}}) begin
            clip = diff[W:0];
        end else begin
            clip = diff[PW] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
        end
        y = sat_w(clip);
    end

endmodule
`default_nettype wire

// File: rtl/gj_row_elim.sv
`default_nettype none
// ============================================================================
// Module      : gj_row_elim
// Description : Row-elimination stage of the fixed-point Gauss-Jordan
//               inverter. Latches the normalized pivot row, then for each
//               matrix row r = 0..N-1 reads the row, subtracts
//               row[pidx] * pivot_row from it (N parallel lanes) and writes
//               it back. The pivot row itself is written back as latched.
// Ports       : clk        in   clock
//               reset_n    in   asynchronous active-low reset
//               start      in   one-cycle request, sampled only in IDLE
//               pivot_idx  in   pivot row/column index, sampled with start
//               pivot_row  in   normalized pivot row, sampled with start
//               rd_addr    out  matrix row read address
//               rd_data    in   row data, valid one cycle after rd_addr
//               wr_en      out  matrix row write strobe
//               wr_addr    out  write row address
//               wr_data    out  write row data
//               busy       out  pass in progress (through the done cycle)
//               done       out  one-cycle completion pulse
//               err        out  sticky bad-pivot flag, cleared on start
//               Row vectors pack element c at bits [c*W +: W].
// Revision    : 1.0  initial release
// ============================================================================
module gj_row_elim #(
    parameter int N    = gj_pkg::N,
    parameter int W    = gj_pkg::W,
    parameter int FRAC = gj_pkg::FRAC,
    parameter int AW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [AW-1:0]     pivot_idx,
    input  logic [N*W-1:0]    pivot_row,
    output logic [AW-1:0]     rd_addr,
    input  logic [N*W-1:0]    rd_data,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [N*W-1:0]    wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import gj_pkg::*;

    localparam logic [AW:0]   N_L      = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

    gj_state_e             state, state_nx;
    logic [AW-1:0]         r;
    logic [AW-1:0]         pidx;
    logic [N*W-1:0]        prow;
    logic [N*W-1:0]        res;
    logic [N*W-1:0]        lane_y;
    logic signed [W-1:0]   factor;
    logic                  bad_idx;

    assign bad_idx = ({1'b0, pivot_idx} >= N_L);

    // Pivot-column element of the row being processed.
    always_comb begin
        factor = '0;
        for (int i = 0; i < N; i++) begin
            if (pidx == AW'(i)) begin
                factor = rd_data[i*W +: W];
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_lane
        fix_msub #(
            .FRAC_BITS (FRAC)
        ) u_lane (
            .a (rd_data[c*W +: W]),
            .f (factor),
            .p (prow[c*W +: W]),
            .y (lane_y[c*W +: W])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            r     <= '0;
            pidx  <= '0;
            prow  <= '0;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        prow <= pivot_row;
                        pidx <= pivot_idx;
                        r    <= '0;
                        err  <= bad_idx;
                    end
                end
                ST_CALC:  res <= lane_y;
                ST_WRITE: begin
                    if (r != LAST_ROW) begin
                        r <= r + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        rd_addr  = r;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        busy     = (state != ST_IDLE);
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = bad_idx ? ST_FINISH : ST_READ;
                end
            end
            ST_READ:  state_nx = ST_CALC;
            ST_CALC:  state_nx = ST_WRITE;
            ST_WRITE: begin
                wr_en    = 1'b1;
                wr_addr  = r;
                wr_data  = (r == pidx) ? prow : res;
                state_nx = (r == LAST_ROW) ? ST_FINISH : ST_READ;
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire
